wb_interconnect_nslv: RTL and testbench
=======================================

Name: wb_interconnect_nslv

Overview:
- Parametrised successor to the fixed 1-master/2-slave Wishbone interconnect in the Caravel user project.
- Routes one Wishbone master (management SoC `wbs_*`) to NUM_SLAVES slaves (SRAM wrapper, UART, future peripherals).
- Decodes a configurable address window, registers the request and waits for the selected slave's ack.
- Returns a bus error for unmapped addresses and for slaves that do not ack within a timeout; counts errors.

Parameters:
- NUM_SLAVES, 4, number of slave ports (2..8).
- BASE_ADDR, 32'h3000_0000, base of the user-area window.
- DEC_LSB, 12, lowest address bit of the slot index; each slot spans 2^DEC_LSB bytes.
- SLV_ADDR_WD, 10, width of the address forwarded to each slave (byte address bits [SLV_ADDR_WD+1:2]).
- TIMEOUT, 255, cycles to wait for a slave ack before erroring (1..65535).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on any error.

Ports:
- wb_clk_i in 1: single clock.
- wb_rst_ni in 1: synchronous reset, active-low.
- m_wb_cyc_i in 1: master cycle.
- m_wb_stb_i in 1: master strobe.
- m_wb_we_i in 1: master write enable.
- m_wb_adr_i in 32: master byte address.
- m_wb_dat_i in 32: master write data.
- m_wb_sel_i in 4: master byte selects.
- m_wb_dat_o out 32: read data to master.
- m_wb_ack_o out 1: transfer acknowledge.
- m_wb_err_o out 1: error qualifier, asserted together with ack.
- s_wb_cyc_o out NUM_SLAVES: per-slave cycle, one-hot.
- s_wb_stb_o out NUM_SLAVES: per-slave strobe, one-hot.
- s_wb_we_o out 1: shared write enable.
- s_wb_adr_o out SLV_ADDR_WD: shared word address.
- s_wb_dat_o out 32: shared write data.
- s_wb_sel_o out 4: shared byte selects.
- s_wb_dat_i in NUM_SLAVES*32: slave read data, slot k at [32k+31:32k].
- s_wb_ack_i in NUM_SLAVES: per-slave ack.
- err_cnt_o out 16: saturating error count.
- err_irq_o out 1: one-cycle pulse on each error.

Behaviour:
- Reset (wb_rst_ni=0 at a clock edge): FSM=IDLE. All outputs 0: ack, err, dat_o, cyc/stb, we, adr, dat, sel, err_cnt_o, err_irq_o. The timer clears. Reset mid-transfer abandons it: no ack, and slave cyc/stb drop at that edge.
- SLOT_BITS = clog2(NUM_SLAVES); slot = adr[DEC_LSB+SLOT_BITS-1:DEC_LSB].
- A request is mapped iff adr[31:DEC_LSB+SLOT_BITS] == BASE_ADDR[31:DEC_LSB+SLOT_BITS] and slot < NUM_SLAVES.
- FSM states: IDLE, FWD, RESP, ERR.
- IDLE:
  - On cyc&stb, latch we/adr/dat/sel and slot.
  - Mapped: go to FWD, and at that edge assert s_wb_cyc_o[slot] and s_wb_stb_o[slot].
  - Unmapped: go to ERR. No slave strobe.
- FWD:
  - Slave outputs are held stable; the timer increments each cycle.
  - s_wb_ack_i[slot]=1: capture its data (0 on writes), deassert cyc/stb, go to RESP.
  - Timer reaches TIMEOUT-1 without ack: deassert cyc/stb, go to ERR.
  - Master drops cyc: abort, deassert cyc/stb, go to IDLE, no ack. Abort takes priority over a same-cycle slave ack.
  - Acks on non-selected slots are ignored in every state.
- RESP: m_wb_ack_o=1 for exactly one cycle with the captured data; err=0; next state IDLE.
- ERR:
  - m_wb_ack_o=1, m_wb_err_o=1 for one cycle; m_wb_dat_o=ERR_DATA for reads, 0 for writes.
  - err_irq_o pulses in the same cycle; err_cnt_o increments and saturates at 16'hFFFF.
  - Next state IDLE.
- m_wb_dat_o is 0 whenever ack=0.
- Latency, counted from the edge that samples the request in IDLE:
  - Slave with combinational ack: master ack 2 cycles later.
  - Unmapped address: ack 1 cycle later.
  - Timeout: ack TIMEOUT+1 cycles later.
- The master follows classic Wishbone: it holds stb until ack and drops it the cycle after. The IDLE state following RESP/ERR may accept a new request immediately, so throughput is one transfer per 3 cycles minimum.

Test Plan:
- Write 0x1234_5678 to 0x3000_1004 (slot 1) with sel=4'hF -> s_wb_stb_o=4'b0010, s_wb_adr_o=1, s_wb_dat_o=0x1234_5678; slave acks the same cycle -> m_wb_ack_o exactly 2 cycles after the request edge, err=0.
- Read 0x3000_3008 with slot 3 returning 0xCAFE_F00D after 5 wait cycles -> ack with 0xCAFE_F00D; cyc/stb held stable for all wait cycles.
- Read 0x3001_0000 (outside window) and 0x3000_5000 with NUM_SLAVES=4 -> no slave strobe; ack+err after 1 cycle, dat=0xDEAD_BEEF; err_cnt_o goes 1 then 2, with one err_irq_o pulse each.
- Slot 2 never acks, TIMEOUT=8 -> slave cyc drops after 8 FWD cycles; ack+err, dat=0xDEAD_BEEF; a late slave ack afterwards is ignored.
- Master drops cyc during FWD, then reset asserted during a later FWD -> no master ack in either case; after reset all outputs 0 and err_cnt_o=0.
- Back-to-back reads slot 0 then slot 1, plus a spurious s_wb_ack_i[2] pulse -> two correct acks with correct data; the spurious ack has no effect.

Source files
------------

// File: rtl/wb_interconnect_nslv.sv
// Single-master to NUM_SLAVES-slave Wishbone interconnect with address-window
// decode, per-transfer ack timeout, bus-error response and a saturating error counter.
module wb_interconnect_nslv #(
  parameter int unsigned NUM_SLAVES  = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned DEC_LSB     = 12,
  parameter int unsigned SLV_ADDR_WD = 10,
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_ni,
  input  logic                       m_wb_cyc_i,
  input  logic                       m_wb_stb_i,
  input  logic                       m_wb_we_i,
  input  logic [31:0]                m_wb_adr_i,
  input  logic [31:0]                m_wb_dat_i,
  input  logic [3:0]                 m_wb_sel_i,
  output logic [31:0]                m_wb_dat_o,
  output logic                       m_wb_ack_o,
  output logic                       m_wb_err_o,
  output logic [NUM_SLAVES-1:0]      s_wb_cyc_o,
  output logic [NUM_SLAVES-1:0]      s_wb_stb_o,
  output logic                       s_wb_we_o,
  output logic [SLV_ADDR_WD-1:0]     s_wb_adr_o,
  output logic [31:0]                s_wb_dat_o,
  output logic [3:0]                 s_wb_sel_o,
  input  logic [NUM_SLAVES*32-1:0]   s_wb_dat_i,
  input  logic [NUM_SLAVES-1:0]      s_wb_ack_i,
  output logic [15:0]                err_cnt_o,
  output logic                       err_irq_o
);

  localparam int unsigned SLOT_BITS = $clog2(NUM_SLAVES);
  localparam int unsigned TAG_LSB   = DEC_LSB + SLOT_BITS;
  localparam int unsigned TMR_WD    = 16;

  typedef enum logic [1:0] {IDLE, FWD, RESP, ERR} state_t;

  state_t                 state_q, state_d;
  logic [SLOT_BITS-1:0]   slot_q, slot_d;
  logic [TMR_WD-1:0]      timer_q, timer_d;
  logic [NUM_SLAVES-1:0]  cyc_d;
  logic                   we_d;
  logic [SLV_ADDR_WD-1:0] adr_d;
  logic [31:0]            sdat_d;
  logic [3:0]             sel_d;
  logic                   ack_d, err_d, irq_d;
  logic [31:0]            mdat_d;
  logic [15:0]            cnt_d;

  logic [SLOT_BITS-1:0]   req_slot_c;
  logic                   req_mapped_c;
  logic [NUM_SLAVES-1:0]  req_onehot_c;
  logic                   sel_ack_c;
  logic [31:0]            sel_dat_c;
  logic                   go_err_c;
  logic                   err_we_c;
  logic                   unused_c;

  assign unused_c = ^m_wb_adr_i[1:0];

  // Address decode of the incoming request and slot-indexed slave response mux.
  always_comb begin
    req_slot_c   = m_wb_adr_i[TAG_LSB-1:DEC_LSB];
    req_mapped_c = (m_wb_adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]) &&
                   (32'(req_slot_c) < NUM_SLAVES);
    req_onehot_c = '0;
    sel_ack_c    = 1'b0;
    sel_dat_c    = '0;
    for (int k = 0; k < int'(NUM_SLAVES); k++) begin
      if (req_slot_c == SLOT_BITS'(k)) req_onehot_c[k] = 1'b1;
      if (slot_q == SLOT_BITS'(k)) begin
        sel_ack_c = s_wb_ack_i[k];
        sel_dat_c = s_wb_dat_i[32*k +: 32];
      end
    end
  end

  // Next-state and next-output logic; response outputs are set on entry to RESP/ERR.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    timer_d  = timer_q;
    cyc_d    = s_wb_cyc_o;
    we_d     = s_wb_we_o;
    adr_d    = s_wb_adr_o;
    sdat_d   = s_wb_dat_o;
    sel_d    = s_wb_sel_o;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    irq_d    = 1'b0;
    mdat_d   = '0;
    cnt_d    = err_cnt_o;
    go_err_c = 1'b0;
    err_we_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (m_wb_cyc_i && m_wb_stb_i) begin
          slot_d  = req_slot_c;
          we_d    = m_wb_we_i;
          adr_d   = m_wb_adr_i[SLV_ADDR_WD+1:2];
          sdat_d  = m_wb_dat_i;
          sel_d   = m_wb_sel_i;
          timer_d = '0;
          if (req_mapped_c) begin
            state_d = FWD;
            cyc_d   = req_onehot_c;
          end else begin
            go_err_c = 1'b1;
            err_we_c = m_wb_we_i;
          end
        end
      end
      FWD: begin
        if (!m_wb_cyc_i) begin
          cyc_d   = '0;
          state_d = IDLE;
        end else if (sel_ack_c) begin
          cyc_d   = '0;
          state_d = RESP;
          ack_d   = 1'b1;
          mdat_d  = s_wb_we_o ? 32'h0 : sel_dat_c;
        end else if (timer_q == TMR_WD'(TIMEOUT - 1)) begin
          cyc_d    = '0;
          go_err_c = 1'b1;
          err_we_c = s_wb_we_o;
        end else begin
          timer_d = timer_q + TMR_WD'(1);
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (go_err_c) begin
      state_d = ERR;
      ack_d   = 1'b1;
      err_d   = 1'b1;
      irq_d   = 1'b1;
      mdat_d  = err_we_c ? 32'h0 : ERR_DATA;
      cnt_d   = (err_cnt_o == 16'hFFFF) ? err_cnt_o : err_cnt_o + 16'd1;
    end
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      timer_q    <= '0;
      s_wb_cyc_o <= '0;
      s_wb_stb_o <= '0;
      s_wb_we_o  <= 1'b0;
      s_wb_adr_o <= '0;
      s_wb_dat_o <= '0;
      s_wb_sel_o <= '0;
      m_wb_ack_o <= 1'b0;
      m_wb_err_o <= 1'b0;
      m_wb_dat_o <= '0;
      err_irq_o  <= 1'b0;
      err_cnt_o  <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      timer_q    <= timer_d;
      s_wb_cyc_o <= cyc_d;
      s_wb_stb_o <= cyc_d;
      s_wb_we_o  <= we_d;
      s_wb_adr_o <= adr_d;
      s_wb_dat_o <= sdat_d;
      s_wb_sel_o <= sel_d;
      m_wb_ack_o <= ack_d;
      m_wb_err_o <= err_d;
      m_wb_dat_o <= mdat_d;
      err_irq_o  <= irq_d;
      err_cnt_o  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_interconnect_nslv.sv
// Directed plus randomized bench for wb_interconnect_nslv against a transaction-level model.
module tb_wb_interconnect_nslv;

  localparam int unsigned NS    = 4;
  localparam int unsigned TO    = 8;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam logic [31:0] EDATA = 32'hDEAD_BEEF;
  localparam int unsigned NEVER = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
  logic [31:0] m_adr = '0, m_dat = '0;
  logic [3:0]  m_sel = '0;
  logic [31:0] m_rdat;
  logic        m_ack, m_err;
  logic [NS-1:0] s_cyc, s_stb, s_ack;
  logic        s_we;
  logic [9:0]  s_adr;
  logic [31:0] s_wdat;
  logic [3:0]  s_sel;
  logic [NS*32-1:0] s_rdat;
  logic [15:0] err_cnt;
  logic        err_irq;

  int unsigned slv_delay [NS];
  logic [31:0] slv_data  [NS];
  logic [NS-1:0] spur_ack = '0;
  int unsigned slv_wait = 0;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned exp_cnt = 0;

  wb_interconnect_nslv #(.NUM_SLAVES(NS), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m_wb_cyc_i(m_cyc), .m_wb_stb_i(m_stb), .m_wb_we_i(m_we),
    .m_wb_adr_i(m_adr), .m_wb_dat_i(m_dat), .m_wb_sel_i(m_sel),
    .m_wb_dat_o(m_rdat), .m_wb_ack_o(m_ack), .m_wb_err_o(m_err),
    .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we),
    .s_wb_adr_o(s_adr), .s_wb_dat_o(s_wdat), .s_wb_sel_o(s_sel),
    .s_wb_dat_i(s_rdat), .s_wb_ack_i(s_ack),
    .err_cnt_o(err_cnt), .err_irq_o(err_irq)
  );

  always #5 clk = ~clk;

  // Behavioural slaves: count strobed cycles, ack when the configured wait has elapsed.
  always @(posedge clk) slv_wait <= (|s_stb) ? slv_wait + 1 : 0;

  always_comb begin
    s_ack = spur_ack;
    for (int k = 0; k < int'(NS); k++) begin
      s_rdat[32*k +: 32] = slv_data[k];
      if (s_stb[k] && slv_wait == slv_delay[k]) s_ack[k] = 1'b1;
    end
  end

  task automatic chk(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, "ack", m_ack, 0);
    chk(tag, "err", m_err, 0);
    chk(tag, "mdat", m_rdat, 0);
    chk(tag, "cyc", s_cyc, 0);
    chk(tag, "stb", s_stb, 0);
    chk(tag, "we_adr_sel", {s_we, s_adr, s_sel}, 0);
    chk(tag, "sdat", s_wdat, 0);
    chk(tag, "cnt", err_cnt, 0);
    chk(tag, "irq", err_irq, 0);
  endtask

  // One classic Wishbone transfer; starts and ends just after a falling edge.
  task automatic xfer(input string tag, input logic we, input logic [31:0] adr,
                      input logic [31:0] wdat, input logic [3:0] sel);
    logic        mapped, exp_errb;
    int unsigned slot, exp_lat, d;
    logic [31:0] exp_dat;
    logic [NS-1:0] exp_oh;
    int n;
    logic got;
    mapped   = (adr >= BASE) && ({32'h0, adr} < {32'h0, BASE} + 64'(NS * 4096));
    slot     = mapped ? (adr - BASE) / 4096 : 0;
    d        = mapped ? slv_delay[slot] : 0;
    exp_errb = !mapped || (d >= TO);
    exp_lat  = !mapped ? 1 : (d < TO) ? d + 2 : TO + 1;
    exp_dat  = we ? 32'h0 : (exp_errb ? EDATA : slv_data[slot]);
    exp_oh   = mapped ? NS'(1 << slot) : '0;
    if (exp_errb && exp_cnt < 16'hFFFF) exp_cnt++;

    m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_adr = adr; m_dat = wdat; m_sel = sel;
    @(posedge clk);
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (m_ack) got = 1'b1;
      else begin
        chk(tag, "cyc_wait", s_cyc, exp_oh);
        chk(tag, "stb_wait", s_stb, exp_oh);
        if (mapped && n == 1) begin
          chk(tag, "s_adr", s_adr, adr[11:2]);
          chk(tag, "s_dat", s_wdat, wdat);
          chk(tag, "s_we_sel", {s_we, s_sel}, {we, sel});
        end
      end
    end
    chk(tag, "latency", got ? n : 999, exp_lat);
    chk(tag, "err", m_err, exp_errb);
    chk(tag, "rdata", m_rdat, exp_dat);
    chk(tag, "irq", err_irq, exp_errb);
    chk(tag, "cnt", err_cnt, exp_cnt);
    chk(tag, "cyc_at_ack", s_cyc, 0);
    @(posedge clk);
    #1 m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk);
    chk(tag, "ack_one_cycle", {m_ack, m_err, err_irq}, 0);
    chk(tag, "mdat_idle", m_rdat, 0);
  endtask

  initial begin
    for (int k = 0; k < int'(NS); k++) begin
      slv_delay[k] = 0;
      slv_data[k]  = 32'h1111_0000 * (k + 1);
    end

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Write to slot 1, combinational ack.
    slv_delay[1] = 0;
    xfer("wr_slot1", 1'b1, 32'h3000_1004, 32'h1234_5678, 4'hF);

    // Read slot 3 with five wait cycles.
    slv_delay[3] = 5; slv_data[3] = 32'hCAFE_F00D;
    xfer("rd_slot3", 1'b0, 32'h3000_3008, 32'h0, 4'hF);

    // Unmapped reads.
    xfer("unmap_hi", 1'b0, 32'h3001_0000, 32'h0, 4'hF);
    xfer("unmap_slot", 1'b0, 32'h3000_5000, 32'h0, 4'hF);

    // Timeout on slot 2, then a late ack that must be ignored.
    slv_delay[2] = NEVER;
    xfer("timeout", 1'b0, 32'h3000_2010, 32'h0, 4'hF);
    spur_ack = 4'b0100;
    repeat (3) begin
      @(negedge clk);
      chk("late_ack", "ack", {m_ack, m_err, err_irq}, 0);
    end
    spur_ack = '0;
    chk("late_ack", "cnt", err_cnt, exp_cnt);

    // Master abort during FWD.
    slv_delay[0] = NEVER;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h3000_0040; m_sel = 4'hF;
    @(posedge clk);
    repeat (3) @(negedge clk);
    chk("abort", "cyc_before", s_cyc, 4'b0001);
    m_cyc = 1'b0; m_stb = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort", "ack", m_ack, 0);
      chk("abort", "cyc", s_cyc, 0);
    end
    chk("abort", "cnt", err_cnt, exp_cnt);

    // Reset during a later FWD.
    slv_delay[1] = NEVER;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_adr = 32'h3000_1100; m_dat = 32'hA5A5_5A5A; m_sel = 4'h3;
    @(posedge clk);
    repeat (2) @(negedge clk);
    chk("rst_fwd", "cyc_before", s_cyc, 4'b0010);
    rst_n = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_fwd");
    exp_cnt = 0;
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back reads with a spurious ack on slot 2.
    slv_delay[0] = 1; slv_data[0] = 32'h0BAD_CAFE;
    slv_delay[1] = 0; slv_data[1] = 32'h600D_D00D;
    spur_ack = 4'b0100;
    xfer("b2b_slot0", 1'b0, 32'h3000_0200, 32'h0, 4'hF);
    xfer("b2b_slot1", 1'b0, 32'h3000_1FFC, 32'h0, 4'hF);
    spur_ack = '0;

    // Randomized transfers.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] adr;
      int unsigned kind, slot;
      kind = $urandom_range(0, 4);
      slot = $urandom_range(0, NS - 1);
      case (kind)
        0: adr = $urandom;
        1: adr = BASE + 32'(NS * 4096) + ($urandom_range(0, 65535) << 2);
        default: adr = BASE + 32'(slot * 4096) + ($urandom_range(0, 1023) << 2);
      endcase
      for (int k = 0; k < int'(NS); k++) begin
        slv_delay[k] = ($urandom_range(0, 5) == 0) ? NEVER : $urandom_range(0, 4);
        slv_data[k]  = $urandom;
      end
      spur_ack = NS'($urandom) & ~(kind >= 2 ? NS'(1 << slot) : NS'(0));
      if (kind >= 2 && adr >= BASE && adr < BASE + 32'(NS * 4096))
        spur_ack = spur_ack & ~NS'(1 << ((adr - BASE) / 4096));
      else if (adr >= BASE && adr < BASE + 32'(NS * 4096))
        spur_ack = '0;
      xfer("rand", 1'($urandom), adr, $urandom, 4'($urandom));
      spur_ack = '0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
